cw_pipe: RTL and testbench

- Parametrised pipeline carrier for the decoded rv32i control word. Replaces the hand-written EX/MEM/WB control registers with one block.
- Accepts one control word per cycle from decode and shifts it through STAGES registered stages.
- Per-stage stall and flush; inserts bubbles automatically.
- Each stage's word and valid bit are exported to the datapath of that stage.

---
 rtl/cw_pipe.sv | 102 ++++++++++
 tb/tb_cw_pipe.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cw_pipe.sv
// Multi-stage carrier for the decoded control word, with per-stage stall/flush and bubble insertion.
// Optional bubble counter enabled by defining CW_PIPE_PERF_EN.
module cw_pipe #(
    parameter int unsigned CW_WIDTH = 36,
    parameter int unsigned STAGES   = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CW_WIDTH-1:0]          cw_in,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [STAGES-1:0]            stall,
    input  logic [STAGES-1:0]            flush,
    output logic [STAGES*CW_WIDTH-1:0]   cw_out,
    output logic [STAGES-1:0]            valid_out,
    output logic                         retire,
    output logic [31:0]                  bubble_count
);

    logic [STAGES-1:0]   w_hold;
    logic [CW_WIDTH-1:0] r_cw [STAGES];
    logic [CW_WIDTH-1:0] w_cw_d [STAGES];
    logic [STAGES-1:0]   r_valid;
    logic [STAGES-1:0]   w_valid_d;

    // A stall anywhere downstream freezes this stage as well.
    for (genvar g = 0; g < STAGES; g++) begin : g_hold
        assign w_hold[g] = |(stall >> g);
    end

    always_comb begin
        w_cw_d    = r_cw;
        w_valid_d = r_valid;

        if (flush[0]) begin
            w_cw_d[0]    = '0;
            w_valid_d[0] = 1'b0;
        end else if (!w_hold[0]) begin
            if (in_valid) begin
                w_cw_d[0]    = cw_in;
                w_valid_d[0] = 1'b1;
            end else begin
                w_cw_d[0]    = '0;
                w_valid_d[0] = 1'b0;
            end
        end

        for (int i = 1; i < int'(STAGES); i++) begin
            if (flush[i]) begin
                w_cw_d[i]    = '0;
                w_valid_d[i] = 1'b0;
            end else if (!w_hold[i]) begin
                // Upstream frozen while this stage moves on: leave a bubble behind.
                if (w_hold[i-1]) begin
                    w_cw_d[i]    = '0;
                    w_valid_d[i] = 1'b0;
                end else begin
                    w_cw_d[i]    = r_cw[i-1];
                    w_valid_d[i] = r_valid[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                r_cw[i] <= '0;
            end
            r_valid <= '0;
        end else begin
            r_cw    <= w_cw_d;
            r_valid <= w_valid_d;
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_out
        assign cw_out[g*CW_WIDTH +: CW_WIDTH] = r_cw[g];
    end

    assign valid_out = r_valid;
    assign in_ready  = ~w_hold[0];
    // Flush of the last stage does not cancel the commit of its word.
    assign retire    = r_valid[STAGES-1] & ~w_hold[STAGES-1];

`ifdef CW_PIPE_PERF_EN
    logic [31:0] r_bubble_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bubble_count <= 32'd0;
        end else if (!r_valid[STAGES-1]) begin
            r_bubble_count <= r_bubble_count + 32'd1;
        end
    end

    assign bubble_count = r_bubble_count;
`else
    assign bubble_count = 32'd0;
`endif

endmodule

// File: tb/tb_cw_pipe.sv
// Randomised and directed bench for cw_pipe, checked against a per-cycle behavioural model.
module tb_cw_pipe;

    localparam int S = 3;
    localparam int W = 36;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [W-1:0]     cw_in = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [S-1:0]     stall = '0;
    logic [S-1:0]     flush = '0;
    logic [S*W-1:0]   cw_out;
    logic [S-1:0]     valid_out;
    logic             retire;
    logic [31:0]      bubble_count;

    logic [7:0]       i1_cw = '0;
    logic             i1_valid = 1'b0;
    logic             i1_ready;
    logic [0:0]       i1_stall = '0;
    logic [0:0]       i1_flush = '0;
    logic [7:0]       i1_cw_out;
    logic [0:0]       i1_valid_out;
    logic             i1_retire;
    logic [31:0]      i1_bubble_count;

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    cw_pipe #(.CW_WIDTH(W), .STAGES(S)) dut (
        .clk          (clk),
        .rst          (rst),
        .cw_in        (cw_in),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .stall        (stall),
        .flush        (flush),
        .cw_out       (cw_out),
        .valid_out    (valid_out),
        .retire       (retire),
        .bubble_count (bubble_count)
    );

    cw_pipe #(.CW_WIDTH(8), .STAGES(1)) dut1 (
        .clk          (clk),
        .rst          (rst),
        .cw_in        (i1_cw),
        .in_valid     (i1_valid),
        .in_ready     (i1_ready),
        .stall        (i1_stall),
        .flush        (i1_flush),
        .cw_out       (i1_cw_out),
        .valid_out    (i1_valid_out),
        .retire       (i1_retire),
        .bubble_count (i1_bubble_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: one word/valid per stage, updated by the stage rules.
    logic [W-1:0] mw [S];
    logic [S-1:0] mv = '0;
    logic [31:0]  mcnt = '0;

    function automatic bit mhold(int i);
        for (int j = i; j < S; j++) if (stall[j]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [W:0] mnext(int i);
        // returns {valid, word}
        if (flush[i]) return '0;
        if (mhold(i)) return {mv[i], mw[i]};
        if (i == 0) return in_valid ? {1'b1, cw_in} : '0;
        if (mhold(i - 1)) return '0;
        return {mv[i-1], mw[i-1]};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < S; i++) mw[i] <= '0;
            mv   <= '0;
            mcnt <= '0;
        end else begin
            for (int i = 0; i < S; i++) begin
                logic [W:0] n;
                n = mnext(i);
                mw[i] <= n[W-1:0];
                mv[i] <= n[W];
            end
            if (!mv[S-1]) mcnt <= mcnt + 32'd1;
        end
    end

    // Per-cycle comparison, well clear of the active edge and after inputs settle.
    always begin
        @(negedge clk);
        #2;
        if (cmp_en) begin
            logic [S*W-1:0] exp_cw;
            logic [31:0]    exp_cnt;
            for (int i = 0; i < S; i++) exp_cw[i*W +: W] = mw[i];
`ifdef CW_PIPE_PERF_EN
            exp_cnt = mcnt;
`else
            exp_cnt = 32'd0;
`endif
            check("cw_out",       128'(cw_out),    128'(exp_cw));
            check("valid_out",    128'(valid_out), 128'(mv));
            check("in_ready",     128'(in_ready),  128'(!mhold(0)));
            check("retire",       128'(retire),    128'(mv[S-1] & !mhold(S-1)));
            check("bubble_count", 128'(bubble_count), 128'(exp_cnt));
        end
    end

    task automatic drive(input logic [W-1:0] c, input logic v, input logic [S-1:0] st,
                         input logic [S-1:0] fl);
        @(negedge clk);
        cw_in    = c;
        in_valid = v;
        stall    = st;
        flush    = fl;
        #3;
    endtask

    logic [31:0] exp_perf;

    initial begin
`ifdef CW_PIPE_PERF_EN
        exp_perf = 32'd4;
`else
        exp_perf = 32'd0;
`endif
        #1 rst = 1'b1;
        #1 cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        #3;
        check("reset_valid",  128'(valid_out), 128'(0));
        check("reset_cw",     128'(cw_out), 128'(0));
        check("reset_retire", 128'(retire), 128'(0));
        check("reset_count",  128'(bubble_count), 128'(0));
        @(negedge clk);
        rst = 1'b0;

        // Stream 1,2,3
        drive(36'h1, 1, 3'b000, 3'b000);
        drive(36'h2, 1, 3'b000, 3'b000);
        drive(36'h3, 1, 3'b000, 3'b000);
        drive(36'h0, 0, 3'b000, 3'b000);
        check("stream_s2_word", 128'(cw_out[2*W +: W]), 128'(36'h1));
        check("stream_valid",   128'(valid_out), 128'(3'b111));
        check("stream_retire",  128'(retire), 128'(1));

        // Load C/B/A, then stall stage 1 for two cycles
        drive(36'hC, 1, 3'b000, 3'b000);
        drive(36'hB, 1, 3'b000, 3'b000);
        drive(36'hA, 1, 3'b000, 3'b000);
        drive(36'hD, 1, 3'b010, 3'b000);
        check("stall_in_ready", 128'(in_ready), 128'(0));
        drive(36'hD, 1, 3'b010, 3'b000);
        check("stall_s0", 128'(cw_out[0 +: W]), 128'(36'hA));
        check("stall_s1", 128'(cw_out[W +: W]), 128'(36'hB));
        check("stall_s2_bubble", 128'(cw_out[2*W +: W]), 128'(0));
        check("stall_valid", 128'(valid_out), 128'(3'b011));
        drive(36'hD, 1, 3'b000, 3'b000);
        drive(36'hF, 1, 3'b000, 3'b000);
        check("release_s2", 128'(cw_out[2*W +: W]), 128'(36'hB));

        // Flush 011 with stall 001: flush wins, stage 2 advances
        drive(36'h7, 1, 3'b001, 3'b011);
        drive(36'h0, 0, 3'b000, 3'b000);
        check("flush_valid", 128'(valid_out), 128'(3'b100));
        check("flush_s01",   128'(cw_out[0 +: 2*W]), 128'(0));
        check("flush_s2",    128'(cw_out[2*W +: W]), 128'(36'hD));

        // Asynchronous reset mid-cycle with a full pipe
        drive(36'h11, 1, 3'b000, 3'b000);
        drive(36'h12, 1, 3'b000, 3'b000);
        drive(36'h13, 1, 3'b000, 3'b000);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_valid",  128'(valid_out), 128'(0));
        check("arst_cw",     128'(cw_out), 128'(0));
        check("arst_retire", 128'(retire), 128'(0));
        @(negedge clk);
        cw_in = '0; in_valid = 1'b0; stall = '0; flush = '0;
        rst = 1'b0;
        repeat (4) drive(36'h0, 0, 3'b000, 3'b000);
        check("idle_count", 128'(bubble_count), 128'(exp_perf));
        check("idle_cw",    128'(cw_out), 128'(0));

        // Single-stage instance
        @(negedge clk);
        i1_cw = 8'hA5; i1_valid = 1'b1; i1_stall = 1'b0;
        @(negedge clk);
        i1_valid = 1'b0; i1_stall = 1'b1;
        #3;
        check("s1_word",   128'(i1_cw_out), 128'(8'hA5));
        check("s1_ready",  128'(i1_ready), 128'(0));
        check("s1_retire", 128'(i1_retire), 128'(0));
        @(negedge clk);
        #3;
        check("s1_hold", 128'(i1_cw_out), 128'(8'hA5));
        @(negedge clk);
        i1_stall = 1'b0;
        #3;
        check("s1_release_retire", 128'(i1_retire), 128'(1));
        @(negedge clk);
        #3;
        check("s1_retire_pulse", 128'(i1_retire), 128'(0));
        check("s1_valid_after",  128'(i1_valid_out), 128'(0));

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            logic [S-1:0] st, fl;
            for (int b = 0; b < S; b++) begin
                st[b] = ($urandom_range(0, 5) == 0);
                fl[b] = ($urandom_range(0, 9) == 0);
            end
            drive({4'($urandom), $urandom}, 1'($urandom_range(0, 3) != 0), st, fl);
            if (n % 500 == 250) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end

        drive(36'h0, 0, 3'b000, 3'b000);
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
